// File: rtl/npc_ras_unit.sv
// npc_ras_unit
// Next-PC generator for the fetch stage. It holds the F-stage PC register and
// resolves the add4, branch-offset, jump-index and jump-register targets. It
// also applies the exception and eret redirects. A circular return-address
// stack (RAS) tracks call/return pairs, and a saturating counter records the
// number of return predictions that fail.
//
// Ports
//   clk, reset      rising-edge clock, synchronous active-high reset
//   stall           hold PC_F and the RAS this cycle
//   ctrl[2:0]       0=add4 1=offset 2=index 3=reg 4=ret (5-7 act as add4)
//   PC_D[31:0]      PC of the instruction in decode
//   offset[31:0]    sign-extended, pre-shifted branch offset
//   index[25:0]     J-type instr_index
//   register[31:0]  forwarded rs value
//   link            decode instruction writes a return address
//   exc_req, eret   exception redirect / return from handler
//   epc[31:0]       eret target
//   PC_F[31:0]      registered fetch PC
//   PCAdd8[31:0]    PC_D+8 (combinational)
//   ras_empty/full  RAS occupancy flags
//   ras_mispredict  ret whose RAS prediction fails (combinational)
//   mispred_cnt     saturating count of mispredicted rets
module npc_ras_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter int          RAS_DEPTH = 8,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       ctrl,
  input  logic [31:0]      PC_D,
  input  logic [31:0]      offset,
  input  logic [25:0]      index,
  input  logic [31:0]      register,
  input  logic             link,
  input  logic             exc_req,
  input  logic             eret,
  input  logic [31:0]      epc,
  output logic [31:0]      PC_F,
  output logic [31:0]      PCAdd8,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_mispredict,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int             PTR_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(RAS_DEPTH);

  logic [31:0]      r_pc;
  logic [PTR_W-1:0] r_top;
  logic [PTR_W:0]   r_count;
  logic [31:0]      r_ras [RAS_DEPTH];
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_active;
  logic             w_is_ret;
  logic             w_push;
  logic             w_pop;
  logic             w_empty;
  logic             w_full;
  logic             w_mispredict;
  logic [31:0]      w_top_val;
  logic [31:0]      w_pc_add8;
  logic [31:0]      w_target;
  logic [31:0]      w_pc_next;
  logic [PTR_W-1:0] w_top_inc;
  logic [PTR_W-1:0] w_top_dec;

  // Redirects and stall suppress all RAS activity and prediction checks.
  assign w_active  = !stall && !exc_req && !eret;
  assign w_is_ret  = (ctrl == 3'd4);
  assign w_empty   = (r_count == {(PTR_W+1){1'b0}});
  assign w_full    = (r_count == DEPTH_C);
  assign w_push    = link && w_active;
  assign w_pop     = w_is_ret && w_active && !w_empty;
  assign w_top_val = r_ras[r_top];
  assign w_pc_add8 = PC_D + 32'd8;
  assign w_top_inc = r_top + PTR_W'(1);
  assign w_top_dec = r_top - PTR_W'(1);

  // An empty stack always counts as a miss, whatever its stale entry holds.
  assign w_mispredict = w_is_ret && w_active && (w_empty || (w_top_val != register));

  // Select the architectural target from the decode-stage control code.
  always_comb begin
    w_target = r_pc + 32'd4;
    case (ctrl)
      3'd0:       w_target = r_pc + 32'd4;
      3'd1:       w_target = PC_D + 32'd4 + offset;
      3'd2:       w_target = {PC_D[31:28], index, 2'b00};
      3'd3, 3'd4: w_target = register;
      default:    w_target = r_pc + 32'd4;
    endcase
  end

  // Redirect priority: exception, then eret, then stall, then normal flow.
  always_comb begin
    w_pc_next = r_pc;
    if (exc_req) begin
      w_pc_next = EXC_ENTRY;
    end else if (eret) begin
      w_pc_next = epc;
    end else if (stall) begin
      w_pc_next = r_pc;
    end else begin
      w_pc_next = w_target;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  // RAS storage. A push into a full stack overwrites the oldest slot. A
  // combined pop and push only rewrites the current top.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_top   <= {PTR_W{1'b0}};
      r_count <= {(PTR_W+1){1'b0}};
      for (int i = 0; i < RAS_DEPTH; i++) begin
        r_ras[i] <= 32'd0;
      end
    end else if (w_push && w_pop) begin
      r_ras[r_top] <= w_pc_add8;
    end else if (w_push) begin
      r_ras[w_top_inc] <= w_pc_add8;
      r_top            <= w_top_inc;
      if (!w_full) begin
        r_count <= r_count + {{PTR_W{1'b0}}, 1'b1};
      end
    end else if (w_pop) begin
      r_top   <= w_top_dec;
      r_count <= r_count - {{PTR_W{1'b0}}, 1'b1};
    end
  end

  // Saturating mispredict counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mispred_cnt <= {CNT_W{1'b0}};
    end else if (w_mispredict && (r_mispred_cnt != {CNT_W{1'b1}})) begin
      r_mispred_cnt <= r_mispred_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign PC_F           = r_pc;
  assign PCAdd8         = w_pc_add8;
  assign ras_empty      = w_empty;
  assign ras_full       = w_full;
  assign ras_mispredict = w_mispredict;
  assign mispred_cnt    = r_mispred_cnt;

endmodule
